// File: rtl/prog_mem_loader_pkg.sv
// rtl/prog_mem_loader_pkg.sv - shared types and constants for the UART program-memory loader
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT_LO,
    ST_CNT_HI,
    ST_DATA,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
  localparam logic [31:0] TEXT_BASE     = 32'h00400000;
  localparam int          CNT_W         = 16;

endpackage

// File: rtl/prog_mem_loader_if.sv
// rtl/prog_mem_loader_if.sv - UART byte input, program-memory write port and load status
interface prog_mem_loader_if #(
  parameter int DATA_WIDTH = 32
);
  import prog_loader_pkg::*;

  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  cpu_hold;
  logic                  load_done;
  logic                  load_err;
  logic [CNT_W-1:0]      words_loaded;

  modport master (
    output rx_data, rx_valid,
    input  mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err, words_loaded
  );

  modport slave (
    input  rx_data, rx_valid,
    output mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err, words_loaded
  );
endinterface

// File: rtl/prog_mem_loader_word_assembler.sv
// rtl/prog_mem_loader_word_assembler.sv - packs four bytes LSB-first into a 32-bit word
module word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_ready
);
  logic [1:0]  r_idx;
  logic [31:0] r_word;
  logic [31:0] w_word;

  // The word includes the byte arriving now, so the caller can register it on the 4th byte's edge
  always_comb begin
    w_word = r_word;
    w_word[{r_idx, 3'b000} +: 8] = i_byte;
  end

  assign o_word       = w_word;
  assign o_word_ready = i_valid && (r_idx == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx  <= 2'd0;
      r_word <= 32'd0;
    end else if (i_clear) begin
      r_idx  <= 2'd0;
    end else if (i_valid) begin
      r_idx  <= r_idx + 2'd1;
      r_word <= w_word;
    end
  end
endmodule

// File: rtl/prog_mem_loader.sv
// rtl/prog_mem_loader.sv - UART boot loader FSM writing framed words to program memory
// Optional trailing XOR checksum byte enabled by PROG_LOADER_CHECKSUM_EN.
module prog_mem_loader
  import prog_loader_pkg::*;
#(
  parameter int                    MEMORY_DEPTH = 256,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = DATA_WIDTH'(TEXT_BASE),
  parameter logic [7:0]            SYNC_BYTE    = SYNC_BYTE_DEF
) (
  input logic              clk,
  input logic              reset,
  prog_mem_loader_if.slave bus
);
  state_t                r_state;
  logic [7:0]            r_count_lo;
  logic [CNT_W-1:0]      r_count;
  logic [CNT_W-1:0]      r_words_loaded;
  logic                  r_mem_we;
  logic [DATA_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic                  r_cpu_hold;
  logic                  r_load_done;
  logic                  r_load_err;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]            r_xor;
`endif

  logic                  w_clear;
  logic                  w_data_valid;
  logic                  w_word_ready;
  logic [31:0]           w_word;
  logic                  w_is_sync;
  logic [CNT_W-1:0]      w_count;
  logic                  w_count_bad;
  logic                  w_last_word;

  assign w_clear      = (r_state == ST_CNT_HI);
  assign w_data_valid = bus.rx_valid && (r_state == ST_DATA);
  assign w_is_sync    = bus.rx_valid && (bus.rx_data == SYNC_BYTE);
  assign w_count      = {bus.rx_data, r_count_lo};
  assign w_count_bad  = (w_count == '0) || ({1'b0, w_count} > (CNT_W + 1)'(MEMORY_DEPTH));
  assign w_last_word  = (r_words_loaded + 1'b1) == r_count;

  word_assembler u_word_assembler (
    .clk          (clk),
    .reset        (reset),
    .i_clear      (w_clear),
    .i_valid      (w_data_valid),
    .i_byte       (bus.rx_data),
    .o_word       (w_word),
    .o_word_ready (w_word_ready)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_count_lo     <= 8'd0;
      r_count        <= '0;
      r_words_loaded <= '0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= BASE_ADDR;
      r_mem_wdata    <= '0;
      r_cpu_hold     <= 1'b1;
      r_load_done    <= 1'b0;
      r_load_err     <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      r_xor          <= 8'd0;
`endif
    end else begin
      r_mem_we <= 1'b0;
      if (w_word_ready) begin
        r_mem_we       <= 1'b1;
        r_mem_addr     <= BASE_ADDR + (DATA_WIDTH'(r_words_loaded) << 2);
        r_mem_wdata    <= DATA_WIDTH'(w_word);
        r_words_loaded <= r_words_loaded + 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_is_sync) r_state <= ST_CNT_LO;
        end
        ST_CNT_LO: begin
          if (bus.rx_valid) begin
            r_count_lo <= bus.rx_data;
            r_state    <= ST_CNT_HI;
          end
        end
        ST_CNT_HI: begin
          if (bus.rx_valid) begin
            r_count <= w_count;
            if (w_count_bad) begin
              r_state    <= ST_ERR;
              r_load_err <= 1'b1;
            end else begin
              r_state        <= ST_DATA;
              r_words_loaded <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
              r_xor          <= 8'd0;
`endif
            end
          end
        end
        ST_DATA: begin
`ifdef PROG_LOADER_CHECKSUM_EN
          if (bus.rx_valid) r_xor <= r_xor ^ bus.rx_data;
          if (w_word_ready && w_last_word) r_state <= ST_CHK;
`else
          if (w_word_ready && w_last_word) r_state <= ST_DONE;
`endif
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        ST_CHK: begin
          if (bus.rx_valid) begin
            if (bus.rx_data == r_xor) begin
              r_state <= ST_DONE;
            end else begin
              r_state    <= ST_ERR;
              r_load_err <= 1'b1;
            end
          end
        end
`endif
        // Status follows DONE one cycle late, so release lands the cycle after the last write
        ST_DONE: begin
          if (w_is_sync) begin
            r_state     <= ST_CNT_LO;
            r_cpu_hold  <= 1'b1;
            r_load_done <= 1'b0;
          end else begin
            r_cpu_hold  <= 1'b0;
            r_load_done <= 1'b1;
          end
        end
        ST_ERR: begin
          if (w_is_sync) begin
            r_state    <= ST_CNT_LO;
            r_load_err <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_we       = r_mem_we;
  assign bus.mem_addr     = r_mem_addr;
  assign bus.mem_wdata    = r_mem_wdata;
  assign bus.cpu_hold     = r_cpu_hold;
  assign bus.load_done    = r_load_done;
  assign bus.load_err     = r_load_err;
  assign bus.words_loaded = r_words_loaded;
endmodule

// File: tb/tb_prog_mem_loader.sv
// tb/tb_prog_mem_loader.sv - directed self-checking bench for prog_mem_loader
module tb_prog_mem_loader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [7:0] tb_xor = 8'd0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  prog_mem_loader_if #(.DATA_WIDTH(32)) bus ();

  prog_mem_loader #(
    .MEMORY_DEPTH (256),
    .DATA_WIDTH   (32),
    .BASE_ADDR    (32'h00400000),
    .SYNC_BYTE    (8'hA5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] log_addr(input int i);
    return (i < wr_addr.size()) ? wr_addr[i] : 32'hxxxxxxxx;
  endfunction

  function automatic logic [31:0] log_data(input int i);
    return (i < wr_data.size()) ? wr_data[i] : 32'hxxxxxxxx;
  endfunction

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_count(input logic [15:0] n);
    tb_xor = 8'd0;
    send_byte(n[7:0]);
    send_byte(n[15:8]);
  endtask

  task automatic send_header(input logic [15:0] n);
    send_byte(8'hA5);
    send_count(n);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      tb_xor = tb_xor ^ w[8*k +: 8];
      send_byte(w[8*k +: 8]);
    end
  endtask

  task automatic finish_frame();
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(tb_xor);
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, ".cpu_hold"},     32'(bus.cpu_hold),     32'd1);
    check({pfx, ".mem_we"},       32'(bus.mem_we),       32'd0);
    check({pfx, ".mem_addr"},     bus.mem_addr,          32'h00400000);
    check({pfx, ".mem_wdata"},    bus.mem_wdata,         32'h00000000);
    check({pfx, ".load_done"},    32'(bus.load_done),    32'd0);
    check({pfx, ".load_err"},     32'(bus.load_err),     32'd0);
    check({pfx, ".words_loaded"}, 32'(bus.words_loaded), 32'd0);
  endtask

  initial begin
    bus.rx_data  = 8'd0;
    bus.rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("rst");
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Two-word frame, back-to-back bytes
    clear_log();
    send_header(16'd2);
    send_word(32'h00500013);
    send_word(32'h00A00093);
    check("t1.we_last",    32'(bus.mem_we),       32'd1);
    check("t1.addr_last",  bus.mem_addr,          32'h00400004);
    check("t1.data_last",  bus.mem_wdata,         32'h00A00093);
    check("t1.wl",         32'(bus.words_loaded), 32'd2);
    check("t1.done_early", 32'(bus.load_done),    32'd0);
    finish_frame();
    check("t1.done",       32'(bus.load_done),    32'd1);
    check("t1.hold",       32'(bus.cpu_hold),     32'd0);
    check("t1.nwr",        32'(wr_addr.size()),   32'd2);
    check("t1.addr0",      log_addr(0),           32'h00400000);
    check("t1.data0",      log_data(0),           32'h00500013);
    check("t1.addr1",      log_addr(1),           32'h00400004);
    check("t1.data1",      log_data(1),           32'h00A00093);

    // Restart from DONE, then reload one word
    clear_log();
    send_byte(8'hA5);
    check("t5.hold_up",    32'(bus.cpu_hold),     32'd1);
    check("t5.done_dn",    32'(bus.load_done),    32'd0);
    send_count(16'd1);
    send_word(32'h00000537);
    finish_frame();
    check("t5.nwr",        32'(wr_addr.size()),   32'd1);
    check("t5.addr0",      log_addr(0),           32'h00400000);
    check("t5.data0",      log_data(0),           32'h00000537);
    check("t5.done",       32'(bus.load_done),    32'd1);

    // Noise before sync is ignored
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_log();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_header(16'd1);
    send_word(32'hDEADBEEF);
    finish_frame();
    check("t2.nwr",        32'(wr_addr.size()),   32'd1);
    check("t2.addr0",      log_addr(0),           32'h00400000);
    check("t2.data0",      log_data(0),           32'hDEADBEEF);
    check("t2.done",       32'(bus.load_done),    32'd1);

    // Count 0 and count 257 both rejected; recovery by a valid frame
    clear_log();
    send_header(16'd0);
    check("t3.err0",       32'(bus.load_err),     32'd1);
    check("t3.hold0",      32'(bus.cpu_hold),     32'd1);
    send_byte(8'h13);
    send_byte(8'h00);
    send_byte(8'hA5);
    check("t3.err_clr",    32'(bus.load_err),     32'd0);
    send_count(16'h0101);
    check("t3.err257",     32'(bus.load_err),     32'd1);
    check("t3.hold257",    32'(bus.cpu_hold),     32'd1);
    check("t3.done257",    32'(bus.load_done),    32'd0);
    check("t3.nowr",       32'(wr_addr.size()),   32'd0);
    send_header(16'd1);
    send_word(32'h12345678);
    finish_frame();
    check("t3.err_rec",    32'(bus.load_err),     32'd0);
    check("t3.done_rec",   32'(bus.load_done),    32'd1);
    check("t3.data_rec",   log_data(0),           32'h12345678);

    // Largest accepted frame: MEMORY_DEPTH words
    clear_log();
    send_header(16'd256);
    for (int i = 0; i < 256; i++) send_word(32'h10000000 + 32'(i));
    finish_frame();
    check("tb.nwr",        32'(wr_addr.size()),   32'd256);
    check("tb.addr1",      log_addr(1),           32'h00400004);
    check("tb.addr_last",  log_addr(255),         32'h004003FC);
    check("tb.data_last",  log_data(255),         32'h100000FF);
    check("tb.wl",         32'(bus.words_loaded), 32'd256);
    check("tb.done",       32'(bus.load_done),    32'd1);

    // Asynchronous reset mid-frame, then a fresh load from the base
    clear_log();
    send_header(16'd2);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    send_byte(8'h66);
    reset = 1'b1;
    #1;
    check_reset_values("t4");
    check("t4.nwr",        32'(wr_addr.size()),   32'd1);
    check("t4.data0",      log_data(0),           32'h44332211);
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_log();
    send_header(16'd1);
    send_word(32'hCAFEF00D);
    finish_frame();
    check("t4.addr_new",   log_addr(0),           32'h00400000);
    check("t4.data_new",   log_data(0),           32'hCAFEF00D);
    check("t4.done",       32'(bus.load_done),    32'd1);

`ifdef PROG_LOADER_CHECKSUM_EN
    // Checksum 0x43 is correct for 13 00 50 00; 0x44 must be rejected
    send_header(16'd1);
    send_word(32'h00500013);
    send_byte(8'h43);
    @(posedge clk);
    #1;
    check("t6.done_ok",    32'(bus.load_done),    32'd1);
    send_header(16'd1);
    send_word(32'h00500013);
    send_byte(8'h44);
    @(posedge clk);
    #1;
    check("t6.err_bad",    32'(bus.load_err),     32'd1);
    check("t6.hold_bad",   32'(bus.cpu_hold),     32'd1);
    check("t6.done_bad",   32'(bus.load_done),    32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/prog_mem_loader.md
Name: prog_mem_loader

Overview:
UART boot-loader controller for the instruction memory of the pipelined RISC-V core. Receives a framed byte stream from the UART RX block and assembles little-endian 32-bit words. Writes each word into the writable program memory at text-segment byte addresses starting at 0x00400000. Holds the CPU in stall/reset until a complete, valid image is loaded.

Parameters:
MEMORY_DEPTH, 256, program memory depth in words; upper bound on accepted word count
DATA_WIDTH, 32, instruction and address width
BASE_ADDR, 32'h00400000, byte address of word 0 (text segment base)
SYNC_BYTE, 8'hA5, frame start marker

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
rx_data  input  8  received UART byte
rx_valid  input  1  one-cycle strobe; rx_data valid this cycle
mem_we  output  1  program-memory write enable, one-cycle pulse per word
mem_addr  output  DATA_WIDTH  byte address of the word being written
mem_wdata  output  DATA_WIDTH  assembled instruction word
cpu_hold  output  1  1 = core held in stall/reset
load_done  output  1  image loaded; level, held
load_err  output  1  frame rejected; level, held
words_loaded  output  16  count of words written in current frame

Behaviour:
- Reset (async, active-high) is valid at any time, including mid-frame. Load aborts; memory keeps any partial contents.
- Reset values: state IDLE, cpu_hold=1, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, load_done=0, load_err=0, words_loaded=0.
- Frame format: SYNC_BYTE, count_lo, count_hi, then 4*count data bytes. Each word is sent LSB byte first.
- Bytes are consumed only on cycles with rx_valid=1. Back-to-back rx_valid on every cycle is supported.
- State IDLE:
  - rx_valid with rx_data==SYNC_BYTE -> CNT_LO.
  - Any other byte is ignored.
- State CNT_LO: capture count[7:0] -> CNT_HI.
- State CNT_HI: capture count[15:8], then check the count.
  - count==0 or count>MEMORY_DEPTH -> ERR.
  - Otherwise -> DATA, with byte_idx=0, words_loaded=0.
- State DATA: byte k (k=0..3) is placed in wdata[8k+7:8k].
  - On the 4th byte, in the next cycle: mem_we=1 for exactly one cycle, mem_addr=BASE_ADDR+4*words_loaded, mem_wdata=assembled word. words_loaded increments in the same cycle.
  - The write happens one cycle after the rx_valid of byte 3. A byte arriving during the write cycle is accepted normally.
- After the write of word count-1 -> DONE (or CHK when the optional feature is enabled).
- State DONE:
  - cpu_hold=0 and load_done=1 from the cycle after the last write.
  - rx_valid with SYNC_BYTE restarts the load: cpu_hold=1 and load_done=0 on the next cycle, state -> CNT_LO. Other bytes are ignored.
- State ERR:
  - cpu_hold=1, load_err=1.
  - SYNC_BYTE clears load_err and goes -> CNT_LO. Other bytes are ignored.
- cpu_hold is 1 in every state except DONE.
- mem_addr is unsigned modulo 2^DATA_WIDTH. The count bound guarantees the address never exceeds BASE_ADDR+4*(MEMORY_DEPTH-1).
- mem_wdata is stable whenever mem_we=1.

Optional Feature:
Macro: PROG_LOADER_CHECKSUM_EN
- Defined:
  - Frame carries one trailing byte after the data: XOR of all 4*count data bytes.
  - Extra state CHK consumes this byte. Match -> DONE. Mismatch -> ERR, with the CPU still held and memory contents not trusted.
- Undefined: no CHK state; the last write goes directly to DONE and no trailing byte is consumed.

Decomposition:
- Package prog_loader_pkg holds:
  - state encoding: IDLE, CNT_LO, CNT_HI, DATA, CHK, DONE, ERR
  - SYNC_BYTE default
  - TEXT_BASE=32'h00400000
  - count width constant (16)
- Sub-module word_assembler: 8-to-32 little-endian shift/insert register with a 2-bit byte counter and a word_ready pulse.
- The FSM, address counter and write strobe stay in prog_mem_loader.

Test Plan:
- Reset, then frame A5 02 00 13 00 50 00 93 00 A0 00 -> mem_we pulses twice: addr 0x00400000 data 0x00500013, then addr 0x00400004 data 0x00A00093. load_done=1 and cpu_hold=0 the cycle after the 2nd write.
- Leading noise bytes 00 FF before A5, then a 1-word frame -> noise ignored; single write at 0x00400000.
- Count 0x0101 (257 > 256) -> ERR, load_err=1, cpu_hold=1, no mem_we. A following valid frame clears load_err and loads correctly.
- Assert reset after 6 data bytes of a 2-word frame -> all outputs at reset values, one write already issued; a new frame then loads from 0x00400000.
- In DONE, send A5 -> cpu_hold rises next cycle, load_done falls; a reload of 1 word succeeds.
- With PROG_LOADER_CHECKSUM_EN: 1-word frame 13 00 50 00 with checksum 0x43 -> DONE. Same frame with checksum 0x44 -> ERR, cpu_hold stays 1.
